// File: rtl/gnn_0_example_save_pkg.sv
// Shared definitions for the save (buffer -> DRAM write-back) path.
package gnn_0_example_save_pkg;

  // Save instruction field positions
  localparam int INST_OFF_LSB    = 64;
  localparam int INST_OFF_W      = 32;
  localparam int INST_LEN_LSB    = 48;
  localparam int INST_LEN_W      = 16;
  localparam int INST_BUF_LSB    = 32;
  localparam int INST_BUF_W      = 16;

  // One buffer line is 64 bytes
  localparam int LINE_BYTES_LOG2 = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_STREAM = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } save_state_e;

  // Lines in flight after this cycle's pop: pending read plus skid entries.
  // A pop only happens when cnt >= 1, so this never underflows.
  function automatic logic [1:0] occupancy(input logic pend, input logic [1:0] cnt,
                                           input logic pop);
    return {1'b0, pend} + cnt - {1'b0, pop};
  endfunction

endpackage

// File: rtl/gnn_0_example_save_skid_fifo.sv
// save_skid_fifo: 2-entry skid buffer that absorbs buffer read data while the
// stream is stalled.
module gnn_0_example_save_skid_fifo #(
  parameter int DW = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);

  logic [1:0][DW-1:0] mem_q, mem_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               do_push, do_pop;

  assign full     = (cnt_q == 2'd2);
  assign empty    = (cnt_q == 2'd0);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // Pointer/count state; reset empties the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Data storage needs no reset: it is only visible through a non-empty head
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/gnn_0_example_save.sv
// gnn_0_example_save: drains a contiguous region of the on-chip line buffer
// onto the AXI write master stream, one instruction per ap_start.
module gnn_0_example_save
  import gnn_0_example_save_pkg::*;
#(
  parameter int SAVE_INST_LENGTH   = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_BUF_ADDR_WIDTH   = 9
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [SAVE_INST_LENGTH-1:0]   ctrl_instruction,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
  output logic                          write_start,
  input  logic                          write_done,
  output logic                          data_tvalid,
  input  logic                          data_tready,
  output logic                          data_tlast,
  output logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata,
  output logic                          save_read_buffer_a_en,
  output logic [C_BUF_ADDR_WIDTH-1:0]   save_read_buffer_a_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] save_read_buffer_a_data
);

  save_state_e                   state_q, state_d;
  logic [INST_LEN_W-1:0]         len_q, len_d;
  logic [INST_LEN_W-1:0]         rd_cnt_q, rd_cnt_d;
  logic [INST_LEN_W-1:0]         beat_q, beat_d;
  logic [C_BUF_ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] xfer_addr_q, xfer_addr_d;
  logic [C_XFER_SIZE_WIDTH-1:0]  xfer_size_q, xfer_size_d;
  logic                          pend_q, pend_d;
  logic                          wd_seen_q, wd_seen_d;

  logic [INST_OFF_W-1:0]         inst_off;
  logic [INST_LEN_W-1:0]         inst_len;
  logic [INST_BUF_W-1:0]         inst_buf;

  logic                          busy, rd_en, last_beat;
  logic                          fifo_pop, fifo_full, fifo_empty;
  logic [1:0]                    fifo_count;
  logic [C_M_AXI_DATA_WIDTH-1:0] fifo_rdata;
  logic                          unused_bits;

  assign inst_off = ctrl_instruction[INST_OFF_LSB +: INST_OFF_W];
  assign inst_len = ctrl_instruction[INST_LEN_LSB +: INST_LEN_W];
  assign inst_buf = ctrl_instruction[INST_BUF_LSB +: INST_BUF_W];

  // Reserved instruction bits, the unused top of the buffer field and the
  // full flag (occupancy is tracked via count) are deliberately ignored.
  assign unused_bits = ^{ctrl_instruction[INST_BUF_LSB-1:0],
                         inst_buf[INST_BUF_W-1:C_BUF_ADDR_WIDTH], fifo_full};

  // Read issue and beat bookkeeping. The first read goes out in ISSUE so the
  // first beat appears three cycles after ap_start. A beat accepted this
  // cycle frees its slot immediately, which keeps 1 beat/cycle sustained.
  always_comb begin
    busy      = (state_q == ST_ISSUE) || (state_q == ST_STREAM);
    fifo_pop  = !fifo_empty && data_tready;
    rd_en     = busy && (rd_cnt_q != len_q) &&
                (occupancy(pend_q, fifo_count, fifo_pop) < 2'd2);
    last_beat = (beat_q == len_q - 16'd1);
  end

  // FSM next-state, instruction latch, counters and sticky write_done
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_cnt_d    = rd_cnt_q;
    beat_d      = beat_q;
    rd_addr_d   = rd_addr_q;
    xfer_addr_d = xfer_addr_q;
    xfer_size_d = xfer_size_q;
    pend_d      = rd_en;
    wd_seen_d   = wd_seen_q;

    if (rd_en) begin
      rd_addr_d = rd_addr_q + 1'b1;   // wraps at the end of the buffer
      rd_cnt_d  = rd_cnt_q + 16'd1;
    end
    if (fifo_pop) beat_d = beat_q + 16'd1;
    if (busy && write_done) wd_seen_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        wd_seen_d = 1'b0;
        if (ap_start) begin
          len_d       = inst_len;
          rd_cnt_d    = '0;
          beat_d      = '0;
          rd_addr_d   = inst_buf[C_BUF_ADDR_WIDTH-1:0];
          xfer_addr_d = ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(inst_off);
          xfer_size_d = C_XFER_SIZE_WIDTH'(inst_len) << LINE_BYTES_LOG2;
          state_d     = (inst_len == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE:  state_d = ST_STREAM;
      ST_STREAM: if (fifo_pop && last_beat) state_d = ST_WAIT;
      ST_WAIT:   if (write_done || wd_seen_q) state_d = ST_DONE;
      ST_DONE: begin
        wd_seen_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any transfer without signalling done
  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      rd_cnt_q    <= '0;
      beat_q      <= '0;
      rd_addr_q   <= '0;
      xfer_addr_q <= '0;
      xfer_size_q <= '0;
      pend_q      <= 1'b0;
      wd_seen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rd_cnt_q    <= rd_cnt_d;
      beat_q      <= beat_d;
      rd_addr_q   <= rd_addr_d;
      xfer_addr_q <= xfer_addr_d;
      xfer_size_q <= xfer_size_d;
      pend_q      <= pend_d;
      wd_seen_q   <= wd_seen_d;
    end
  end

  // Read data lands one cycle after the enable and goes straight into the skid
  gnn_0_example_save_skid_fifo #(
    .DW (C_M_AXI_DATA_WIDTH)
  ) u_skid (
    .clk       (kernel_clk),
    .rst       (kernel_rst),
    .push      (pend_q),
    .push_data (save_read_buffer_a_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign write_start             = (state_q == ST_ISSUE);
  assign ap_done                 = (state_q == ST_DONE);
  assign dram_xfer_start_addr    = xfer_addr_q;
  assign dram_xfer_size_in_bytes = xfer_size_q;
  assign data_tvalid             = !fifo_empty;
  assign data_tlast              = !fifo_empty && last_beat;
  assign data_tdata              = fifo_empty ? '0 : fifo_rdata;
  assign save_read_buffer_a_en   = rd_en;
  assign save_read_buffer_a_addr = rd_addr_q;

endmodule

// File: tb/tb_gnn_0_example_save.sv
// Bench for gnn_0_example_save: buffer model, tready shaping, beat scoreboard.
module tb_gnn_0_example_save;

  localparam int DW = 512;

  logic           kernel_clk = 1'b0;
  logic           kernel_rst = 1'b1;
  logic           ap_start = 1'b0;
  logic           ap_done;
  logic [63:0]    ctrl_addr_offset = '0;
  logic [95:0]    ctrl_instruction = '0;
  logic [63:0]    dram_xfer_start_addr;
  logic [31:0]    dram_xfer_size_in_bytes;
  logic           write_start;
  logic           write_done = 1'b0;
  logic           data_tvalid;
  logic           data_tready = 1'b0;
  logic           data_tlast;
  logic [DW-1:0]  data_tdata;
  logic           save_read_buffer_a_en;
  logic [8:0]     save_read_buffer_a_addr;
  logic [DW-1:0]  save_read_buffer_a_data = '0;

  gnn_0_example_save dut (
    .kernel_clk              (kernel_clk),
    .kernel_rst              (kernel_rst),
    .ap_start                (ap_start),
    .ap_done                 (ap_done),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_instruction        (ctrl_instruction),
    .dram_xfer_start_addr    (dram_xfer_start_addr),
    .dram_xfer_size_in_bytes (dram_xfer_size_in_bytes),
    .write_start             (write_start),
    .write_done              (write_done),
    .data_tvalid             (data_tvalid),
    .data_tready             (data_tready),
    .data_tlast              (data_tlast),
    .data_tdata              (data_tdata),
    .save_read_buffer_a_en   (save_read_buffer_a_en),
    .save_read_buffer_a_addr (save_read_buffer_a_addr),
    .save_read_buffer_a_data (save_read_buffer_a_data)
  );

  always #5 kernel_clk = ~kernel_clk;

  // Buffer contents are a pure function of the line address
  function automatic logic [DW-1:0] line_of(input logic [8:0] a);
    logic [DW-1:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = {a, 4'(k), 19'h12345};
    return r;
  endfunction

  always @(posedge kernel_clk)
    if (save_read_buffer_a_en) save_read_buffer_a_data <= line_of(save_read_buffer_a_addr);

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  beat_t sb[$];

  typedef struct {
    logic [31:0] off; logic [15:0] len; logic [15:0] bst; logic [63:0] coff;
    int mode; logic [63:0] eaddr; logic [31:0] esize;
  } vec_t;

  int total = 0, bad = 0, cyc = 0;
  int ws_cnt, done_cnt, tv_cnt, en_cnt, beats_seen;
  int ws_cyc, done_cyc, first_tv_cyc, first_fire_cyc, last_fire_cyc;
  int tmode = 0;
  bit stall = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Monitor: event counters, tready shaping, beat scoreboard, stall stability
  always @(negedge kernel_clk) begin
    cyc++;
    if (kernel_rst) begin
      prev_stall  = 1'b0;
      data_tready = 1'b0;
    end else begin
      if (write_start) begin ws_cnt++; ws_cyc = cyc; end
      if (ap_done) begin done_cnt++; done_cyc = cyc; end
      if (save_read_buffer_a_en) en_cnt++;
      if (data_tvalid) begin
        tv_cnt++;
        if (first_tv_cyc < 0) first_tv_cyc = cyc;
      end
      if (prev_stall) begin
        total++;
        if (!data_tvalid || data_tdata !== prev_data) begin
          bad++;
          $display("FAIL stall_hold: tvalid=%0b data changed=%0b", data_tvalid,
                   data_tdata !== prev_data);
        end
      end
      case (tmode)
        0:       data_tready = 1'b1;
        1:       data_tready = ~data_tready;
        default: data_tready = 1'($urandom_range(0, 1));
      endcase
      if (stall) data_tready = 1'b0;
      if (data_tvalid && data_tready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got data[31:0]=%0h want no beat", data_tdata[31:0]);
        end else begin
          beat_t e;
          e = sb.pop_front();
          if (data_tdata !== e.data || data_tlast !== e.last) begin
            bad++;
            $display("FAIL beat%0d: got w0=%0h last=%0b want w0=%0h last=%0b", beats_seen,
                     data_tdata[31:0], data_tlast, e.data[31:0], e.last);
          end
        end
        if (first_fire_cyc < 0) first_fire_cyc = cyc;
        last_fire_cyc = cyc;
        beats_seen++;
      end
      prev_stall = data_tvalid && !data_tready;
      prev_data  = data_tdata;
    end
  end

  task automatic clr_counts();
    ws_cnt = 0; done_cnt = 0; tv_cnt = 0; en_cnt = 0; beats_seen = 0;
    ws_cyc = -1; done_cyc = -1; first_tv_cyc = -1; first_fire_cyc = -1; last_fire_cyc = -1;
  endtask

  task automatic push_expect(input logic [15:0] len, input logic [15:0] bst);
    logic [8:0] a;
    a = bst[8:0];
    for (int i = 0; i < int'(len); i++) begin
      sb.push_back('{line_of(a), (i == int'(len) - 1)});
      a = a + 9'd1;
    end
  endtask

  task automatic wait_beats(input int n);
    int to;
    to = 0;
    while (beats_seen < n && to < 2000) begin @(negedge kernel_clk); #1; to++; end
    if (to >= 2000) begin bad++; total++; $display("FAIL beat_timeout: got=%0d want=%0d", beats_seen, n); end
  endtask

  // One full instruction with the write master answering after the last beat,
  // or (early=1) answering mid-stream alongside an ignored second ap_start.
  task automatic run_txn(input vec_t v, input bit early);
    int c0, w;
    clr_counts();
    tmode = v.mode;
    push_expect(v.len, v.bst);
    @(negedge kernel_clk); #1;
    c0 = cyc;
    ctrl_addr_offset = v.coff;
    ctrl_instruction = {v.off, v.len, v.bst, 32'hDEADBEEF};
    ap_start = 1'b1;
    @(negedge kernel_clk); #1;
    ap_start = 1'b0;
    if (early) begin
      wait_beats(1);
      write_done = 1'b1;
      ctrl_instruction = {32'h0000_0800, 16'd3, 16'd7, 32'h0};
      ap_start = 1'b1;
      @(negedge kernel_clk); #1;
      write_done = 1'b0;
      ap_start = 1'b0;
    end
    wait_beats(int'(v.len));
    chk("beat_count", 64'(beats_seen), 64'(v.len));
    if (early) begin
      repeat (4) @(negedge kernel_clk);
      #1;
      chk("done_after_last_beat", 64'(done_cyc), 64'(last_fire_cyc + 2));
    end else begin
      repeat (2) @(negedge kernel_clk);
      #1;
      chk("no_done_before_write_done", 64'(done_cnt), 64'd0);
      write_done = 1'b1;
      w = cyc;
      @(negedge kernel_clk); #1;
      write_done = 1'b0;
      chk("done_latency", 64'(done_cyc), 64'(w + 1));
    end
    repeat (3) @(negedge kernel_clk);
    #1;
    chk("write_start_count", 64'(ws_cnt), 64'd1);
    chk("write_start_cycle", 64'(ws_cyc - c0), 64'd1);
    chk("first_tvalid_latency", 64'(first_tv_cyc - c0), 64'd3);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("xfer_addr", dram_xfer_start_addr, v.eaddr);
    chk("xfer_size", 64'(dram_xfer_size_in_bytes), 64'(v.esize));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    if (v.mode == 0) chk("throughput", 64'(last_fire_cyc - first_fire_cyc), 64'(v.len - 16'd1));
  endtask

  vec_t tbl[4];

  initial begin
    vec_t v;
    int c0;
    tbl[0] = '{32'h0000_1000, 16'd2,  16'd0,   64'h0,                0, 64'h1000,          32'd128};
    tbl[1] = '{32'h0000_2000, 16'd16, 16'd12,  64'h0,                1, 64'h2000,          32'd1024};
    tbl[2] = '{32'h0000_0300, 16'd4,  16'd510, 64'h0,                0, 64'h0300,          32'd256};
    tbl[3] = '{32'h8000_0040, 16'd3,  16'd100, 64'h0000_0001_FFFF_FFF0, 2, 64'h0000_0002_8000_0030, 32'd192};

    clr_counts();
    repeat (3) @(negedge kernel_clk);
    #1;
    chk("rst_write_start", 64'(write_start), 64'd0);
    chk("rst_ap_done", 64'(ap_done), 64'd0);
    chk("rst_tvalid", 64'(data_tvalid), 64'd0);
    chk("rst_en", 64'(save_read_buffer_a_en), 64'd0);
    chk("rst_size", 64'(dram_xfer_size_in_bytes), 64'd0);
    kernel_rst = 1'b0;

    for (int i = 0; i < 4; i++) run_txn(tbl[i], 1'b0);

    // Early write_done plus an ignored mid-transfer ap_start
    v = '{32'h0000_4000, 16'd6, 16'd40, 64'h10, 1, 64'h4010, 32'd384};
    run_txn(v, 1'b1);
    repeat (4) @(negedge kernel_clk);
    #1;
    chk("ignored_start_no_ws", 64'(ws_cnt), 64'd1);
    chk("ignored_start_no_done", 64'(done_cnt), 64'd1);

    // Zero-length instruction: done only, nothing on the stream
    clr_counts();
    tmode = 0;
    @(negedge kernel_clk); #1;
    c0 = cyc;
    ctrl_addr_offset = 64'h100;
    ctrl_instruction = {32'h40, 16'd0, 16'd5, 32'h0};
    ap_start = 1'b1;
    @(negedge kernel_clk); #1;
    ap_start = 1'b0;
    repeat (5) @(negedge kernel_clk);
    #1;
    chk("l0_write_start", 64'(ws_cnt), 64'd0);
    chk("l0_tvalid", 64'(tv_cnt), 64'd0);
    chk("l0_reads", 64'(en_cnt), 64'd0);
    chk("l0_done_count", 64'(done_cnt), 64'd1);
    chk("l0_done_window", 64'((done_cyc - c0 >= 1) && (done_cyc - c0 <= 2)), 64'd1);
    chk("l0_addr", dram_xfer_start_addr, 64'h140);
    chk("l0_size", 64'(dram_xfer_size_in_bytes), 64'd0);

    // Reset in the middle of an L=8 stream after three beats
    clr_counts();
    tmode = 0;
    push_expect(16'd8, 16'd200);
    @(negedge kernel_clk); #1;
    ctrl_addr_offset = 64'h0;
    ctrl_instruction = {32'h9000, 16'd8, 16'd200, 32'h0};
    ap_start = 1'b1;
    @(negedge kernel_clk); #1;
    ap_start = 1'b0;
    wait_beats(3);
    stall = 1'b1;
    @(negedge kernel_clk); #1;
    chk("pre_rst_beats", 64'(beats_seen), 64'd3);
    kernel_rst = 1'b1;
    @(negedge kernel_clk); #1;
    chk("mid_rst_tvalid", 64'(data_tvalid), 64'd0);
    chk("mid_rst_tlast", 64'(data_tlast), 64'd0);
    chk("mid_rst_tdata", 64'(|data_tdata), 64'd0);
    chk("mid_rst_write_start", 64'(write_start), 64'd0);
    chk("mid_rst_ap_done", 64'(ap_done), 64'd0);
    chk("mid_rst_en", 64'(save_read_buffer_a_en), 64'd0);
    chk("mid_rst_rd_addr", 64'(save_read_buffer_a_addr), 64'd0);
    chk("mid_rst_xfer_addr", dram_xfer_start_addr, 64'd0);
    chk("mid_rst_xfer_size", 64'(dram_xfer_size_in_bytes), 64'd0);
    kernel_rst = 1'b0;
    stall = 1'b0;
    sb.delete();
    clr_counts();
    repeat (6) @(negedge kernel_clk);
    #1;
    chk("post_rst_no_done", 64'(done_cnt), 64'd0);
    chk("post_rst_no_beats", 64'(tv_cnt), 64'd0);
    v = '{32'h0000_0080, 16'd1, 16'd33, 64'h1_0000, 0, 64'h1_0080, 32'd64};
    run_txn(v, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
